control_execute_pipe: RTL and testbench
=======================================

// Module: control_execute_pipe
// PURPOSE
//  Registered, parametrised execute-stage control decoder. Accepts one instruction per valid/ready
//  handshake from decode and presents ALU opcode, shamt, immediate and i_signal to execute.
//  Stalls R-type mul/div for a programmable latency. Flushes on branch mispredict.
// PARAMETERS
//  DATA_W    32  width of instruction and immediate_value
//  IMM_W     17  immediate field width (instruction[IMM_W-1:0])
//  SIGN_EXT  0   1: sign-extend immediate from bit IMM_W-1; 0: zero-extend
//  MD_LAT    4   execute cycles held for mul/div (>=1); counter width $clog2(MD_LAT+1)
// PORTS
//  clock            in   1       single clock, rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  in_valid         in   1       decode presents instruction
//  in_ready         out  1       block can accept this cycle
//  instruction      in   DATA_W  opcode [31:27], shamt [11:7], ALU op [6:2]
//  flush            in   1       kill held/in-flight entry (mispredict)
//  out_valid        out  1       decoded controls valid to execute
//  out_ready        in   1       execute consumes this cycle
//  ALU_opcode       out  5       ALU operation
//  ctrl_shamt       out  5       shift amount
//  immediate_value  out  DATA_W  extended immediate
//  i_signal         out  1       select immediate over register operand B
//  md_busy          out  1       mul/div latency counter running
// BEHAVIOUR
//  - Reset: state=EMPTY; all outputs 0 except in_ready=1.
//  - Decode (comb, captured at accept): opcode 00101/00111/01000 (addi,sw,lw) -> ALU 00000, i_signal=1;
//    00010/00110 (bne,blt) -> ALU 00001, i_signal=0; else ALU=instruction[6:2], i_signal=0.
//    ctrl_shamt=instruction[11:7]; immediate per SIGN_EXT, upper bits filled to DATA_W.
//  - Accept when in_valid & in_ready; controls register on that edge; latency 1 cycle to out_valid.
//  - States: EMPTY -> FULL on accept of non-mul/div; EMPTY -> MD on accept of opcode 00000 with
//    ALU op 00110 (mul) or 00111 (div), counter loaded MD_LAT.
//  - MD: md_busy=1, out_valid=0, in_ready=0; counter decrements per cycle; at 0 -> FULL (out_valid=1).
//  - FULL: out_valid=1, outputs held stable until out_ready. in_ready = EMPTY | (FULL & out_ready):
//    simultaneous consume + accept reloads the register with no bubble (FULL->FULL or FULL->MD).
//  - FULL & out_ready & no accept -> EMPTY; outputs keep last value, out_valid=0.
//  - flush (highest priority): next state EMPTY, out_valid=0, md_busy=0, counter cleared;
//    in_ready=0 in the flush cycle, so an instruction presented with flush is not accepted.
//  - reset_n low mid-operation (any state) -> immediate return to reset values, counter cleared.
//  - Backpressure: out_ready low in FULL never alters outputs; no entry dropped or duplicated.
// CONFIGURATION
//  CONTROL_EXECUTE_ILLEGAL_EN defined: adds output illegal_op (1 bit, reset 0), registered with
//  the entry. Set for opcodes outside {00000,00010,00101,00110,00111,01000}. Entry then decodes as
//  NOP: ALU 00000, i_signal=0, immediate 0, shamt 0. Never enters MD.
//  Undefined: port absent; unknown opcodes take R-type path (ALU=instruction[6:2]).
// TESTING
//  1 addi (opcode 00101, imm 17'h1FFFF), SIGN_EXT=0 -> ALU 00000, i_signal=1, imm 32'h0001FFFF;
//    SIGN_EXT=1 -> imm 32'hFFFFFFFF; out_valid 1 cycle after accept.
//  2 R-type mul (ALU op 00110), MD_LAT=4 -> md_busy 4 cycles, in_ready 0, then out_valid=1.
//  3 Back-to-back add,sub,or with out_ready=1 -> 3 accepts in 3 cycles, no bubble; out_ready held 0
//    3 cycles -> outputs stable, in_ready 0.
//  4 flush during MD (counter=2) and during FULL -> next cycle out_valid=0, md_busy=0, in_ready=1.
//  5 reset_n low asynchronously mid-MD -> all outputs 0, in_ready=1 before next clock edge.
//  6 opcode 11111 with CONTROL_EXECUTE_ILLEGAL_EN -> illegal_op=1, ALU 00000; without -> ALU=[6:2].

Source files
------------

// File: rtl/control_execute_pipe.sv
// rtl/control_execute_pipe.sv - registered execute-stage control decoder with mul/div stall and flush
// Optional feature macro: CONTROL_EXECUTE_ILLEGAL_EN (adds illegal_op, unknown opcodes decode as NOP)
module control_execute_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 17,
  parameter int SIGN_EXT = 0,
  parameter int MD_LAT   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instruction,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        ALU_opcode,
  output logic [4:0]        ctrl_shamt,
  output logic [DATA_W-1:0] immediate_value,
  output logic              i_signal,
  output logic              md_busy
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
  ,
  output logic              illegal_op
`endif
);

  localparam int CW = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {EMPTY, FULL, MD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        opcode, alu_d, shamt_d;
  logic              isig_d, md_d, accept;
  logic [DATA_W-1:0] imm_d;
  logic              unused_bits;
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
  logic              ill_d;
`endif

  assign unused_bits = ^instruction[DATA_W-1:IMM_W];

  always_comb begin
    opcode  = instruction[31:27];
    alu_d   = instruction[6:2];
    shamt_d = instruction[11:7];
    isig_d  = 1'b0;
    imm_d   = '0;
    imm_d[IMM_W-1:0] = instruction[IMM_W-1:0];
    if (SIGN_EXT != 0 && instruction[IMM_W-1]) imm_d[DATA_W-1:IMM_W] = '1;
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
    ill_d = 1'b0;
`endif
    case (opcode)
      5'b00101, 5'b00111, 5'b01000: begin
        alu_d  = 5'b00000;
        isig_d = 1'b1;
      end
      5'b00010, 5'b00110: alu_d = 5'b00001;
      5'b00000: ;
      default: begin
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
        ill_d   = 1'b1;
        alu_d   = 5'b00000;
        shamt_d = 5'b00000;
        imm_d   = '0;
`endif
      end
    endcase
    // Only R-type mul/div stalls; illegal entries already have alu_d forced to 0.
    md_d = (opcode == 5'b00000) && (alu_d == 5'b00110 || alu_d == 5'b00111);
  end

  assign in_ready  = ~flush & ((state_q == EMPTY) | ((state_q == FULL) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == FULL);
  assign md_busy   = (state_q == MD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = md_d ? MD : FULL;
      cnt_d   = md_d ? CW'(MD_LAT) : '0;
    end else begin
      case (state_q)
        FULL: if (out_ready) state_d = EMPTY;
        MD: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FULL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= EMPTY;
      cnt_q           <= '0;
      ALU_opcode      <= '0;
      ctrl_shamt      <= '0;
      immediate_value <= '0;
      i_signal        <= 1'b0;
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
      illegal_op      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ALU_opcode      <= alu_d;
        ctrl_shamt      <= shamt_d;
        immediate_value <= imm_d;
        i_signal        <= isig_d;
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
        illegal_op      <= ill_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_control_execute_pipe.sv
// tb/tb_control_execute_pipe.sv - randomized bench for control_execute_pipe against a timestamp model
module tb_control_execute_pipe;

  localparam int MD_LAT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_ready, out_valid, i_signal, md_busy;
  logic [4:0]  ALU_opcode, ctrl_shamt;
  logic [31:0] immediate_value;
  logic        sx_in_ready, sx_out_valid, sx_i_signal, sx_md_busy;
  logic [4:0]  sx_alu, sx_shamt;
  logic [31:0] sx_imm;
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
  logic        illegal_op, sx_illegal_op;
`endif

  always #5 clock = ~clock;

  control_execute_pipe #(.DATA_W(32), .IMM_W(17), .SIGN_EXT(0), .MD_LAT(MD_LAT)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_opcode(ALU_opcode), .ctrl_shamt(ctrl_shamt), .immediate_value(immediate_value),
    .i_signal(i_signal), .md_busy(md_busy)
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
    , .illegal_op(illegal_op)
`endif
  );

  control_execute_pipe #(.DATA_W(32), .IMM_W(17), .SIGN_EXT(1), .MD_LAT(MD_LAT)) u_dut_sx (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(sx_in_ready),
    .instruction(instruction), .flush(flush), .out_valid(sx_out_valid), .out_ready(out_ready),
    .ALU_opcode(sx_alu), .ctrl_shamt(sx_shamt), .immediate_value(sx_imm),
    .i_signal(sx_i_signal), .md_busy(sx_md_busy)
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
    , .illegal_op(sx_illegal_op)
`endif
  );

  typedef struct {
    logic [4:0]  alu;
    logic [4:0]  shamt;
    logic        isig;
    logic [31:0] imm_z;
    logic [31:0] imm_s;
    logic        md;
    logic        ill;
  } ent_t;

  int   checks = 0, failures = 0;
  int   cyc = 0, ready_cyc = 0;
  bit   have = 0, last_acc = 0;
  ent_t cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic ent_t ref_decode(input logic [31:0] ins);
    ent_t e;
    logic [4:0] op = ins[31:27];
    e.alu = ins[6:2];
    e.shamt = ins[11:7];
    e.isig = 1'b0;
    e.ill = 1'b0;
    e.imm_z = {15'd0, ins[16:0]};
    e.imm_s = ins[16] ? (32'hFFFE0000 | e.imm_z) : e.imm_z;
    if (op == 5'd5 || op == 5'd7 || op == 5'd8) begin
      e.alu = 5'd0;
      e.isig = 1'b1;
    end else if (op == 5'd2 || op == 5'd6) begin
      e.alu = 5'd1;
    end
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
    if (!(op inside {5'd0, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8})) begin
      e.ill = 1'b1; e.alu = 5'd0; e.isig = 1'b0; e.shamt = 5'd0; e.imm_z = '0; e.imm_s = '0;
    end
`endif
    e.md = (op == 5'd0) && !e.ill && (e.alu == 5'd6 || e.alu == 5'd7);
    return e;
  endfunction

  function automatic ent_t zero_ent();
    ent_t e;
    e.alu = '0; e.shamt = '0; e.isig = 0; e.imm_z = '0; e.imm_s = '0; e.md = 0; e.ill = 0;
    return e;
  endfunction

  task automatic check_all();
    bit vis = have && (cyc >= ready_cyc);
    bit rdy = !flush && (!have || (vis && out_ready));
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, vis});
    check_eq("md_busy", {31'd0, md_busy}, {31'd0, have && !vis});
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check_eq("alu", {27'd0, ALU_opcode}, {27'd0, cur.alu});
    check_eq("shamt", {27'd0, ctrl_shamt}, {27'd0, cur.shamt});
    check_eq("i_signal", {31'd0, i_signal}, {31'd0, cur.isig});
    check_eq("imm_zext", immediate_value, cur.imm_z);
    check_eq("imm_sext", sx_imm, cur.imm_s);
    check_eq("sx_md_busy", {31'd0, sx_md_busy}, {31'd0, have && !vis});
`ifdef CONTROL_EXECUTE_ILLEGAL_EN
    check_eq("illegal_op", {31'd0, illegal_op}, {31'd0, cur.ill});
`endif
  endtask

  // Sample at negedge, then advance the model across the following rising edge.
  task automatic step();
    bit vis, acc, cons;
    @(negedge clock);
    check_all();
    vis  = have && (cyc >= ready_cyc);
    acc  = in_valid && !flush && (!have || (vis && out_ready));
    cons = vis && out_ready;
    @(posedge clock);
    cyc++;
    last_acc = acc;
    if (flush) have = 0;
    else if (acc) begin
      cur = ref_decode(instruction);
      have = 1;
      ready_cyc = cyc + (cur.md ? MD_LAT : 0);
    end else if (cons) have = 0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    int sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: begin
        ins[31:27] = 5'd0;
        if ($urandom_range(0, 2) == 0) ins[6:2] = 5'd6 + 5'($urandom_range(0, 1));
      end
      3: ins[31:27] = 5'd2;
      4: ins[31:27] = 5'd5;
      5: ins[31:27] = 5'd6;
      6: ins[31:27] = 5'd7;
      7: ins[31:27] = 5'd8;
      8: ins[31:27] = 5'd31;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    cur = zero_ent();
    #3;
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // addi with all-ones immediate: zero- and sign-extended forms
    in_valid = 1; instruction = {5'b00101, 10'd0, 17'h1FFFF};
    step();
    in_valid = 0;
    @(negedge clock);
    check_eq("addi_imm_z", immediate_value, 32'h0001FFFF);
    check_eq("addi_imm_s", sx_imm, 32'hFFFFFFFF);
    check_eq("addi_alu", {27'd0, ALU_opcode}, 32'd0);
    check_eq("addi_isig", {31'd0, i_signal}, 32'd1);
    check_eq("addi_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clock); #1;

    // mul accepted, then async reset in the middle of the stall
    in_valid = 1; out_ready = 1; instruction = 32'h0000_0018;
    last_acc = 0;
    for (int i = 0; i < 6 && !last_acc; i++) step();
    check_eq("mul_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 0; out_ready = 0;
    step(); step();
    check_eq("mid_md_busy", {31'd0, md_busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    cur = zero_ent(); have = 0;
    check_all();
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 11) == 0);
      instruction = rand_instr();
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
